seg_595_scan_ctrl: RTL and testbench

//  Dynamic-scan scheduler for a 6-digit common-anode 7-segment display driven through a

---
 rtl/seg_595_scan_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg_595_scan_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_595_scan_ctrl.sv
// Dynamic-scan scheduler: 6 BCD digits -> 14-bit {sel,seg} words shifted into a cascaded 74HC595 pair.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit0 never blanked).
module seg_595_scan_ctrl #(
  parameter int cnt_scan_max = 50_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] bcd_data,
  input  logic [5:0]  dp_en,
  input  logic        seg_en,
  output logic        stcp,
  output logic        shcp,
  output logic        ds,
  output logic        oe,
  output logic        frame_done
);

  localparam int HOLD_W = (cnt_scan_max > 1) ? $clog2(cnt_scan_max) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, HOLD} state_t;

  state_t            state;
  logic [2:0]        digit_idx;
  logic [3:0]        bit_cnt;
  logic [1:0]        phase;
  logic [HOLD_W-1:0] hold_cnt;

  logic [23:0] frame_bcd;
  logic [5:0]  frame_dp;
  logic [13:0] word;

  logic [23:0] cur_bcd;
  logic [5:0]  cur_dp;
  logic [23:0] bcd_sh;
  logic [3:0]  cur_digit;
  logic        blank_digit;
  logic [7:0]  seg_code;
  logic [5:0]  sel;

  function automatic logic [7:0] decode_seg(input logic [3:0] d);
    case (d)
      4'd0:    decode_seg = 8'hC0;
      4'd1:    decode_seg = 8'hF9;
      4'd2:    decode_seg = 8'hA4;
      4'd3:    decode_seg = 8'hB0;
      4'd4:    decode_seg = 8'h99;
      4'd5:    decode_seg = 8'h92;
      4'd6:    decode_seg = 8'h82;
      4'd7:    decode_seg = 8'hF8;
      4'd8:    decode_seg = 8'h80;
      4'd9:    decode_seg = 8'h90;
      default: decode_seg = 8'hFF;
    endcase
  endfunction

  // digit0's LOAD takes the snapshot in the same cycle, so it decodes straight from the inputs
  always_comb begin
    cur_bcd   = (digit_idx == 3'd0) ? bcd_data : frame_bcd;
    cur_dp    = (digit_idx == 3'd0) ? dp_en    : frame_dp;
    bcd_sh    = cur_bcd >> {digit_idx, 2'b00};
    cur_digit = bcd_sh[3:0];
    sel       = 6'b000001 << digit_idx;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0] lead_zero;

  always_comb begin
    lead_zero    = 6'b000000;
    lead_zero[5] = (cur_bcd[23:20] == 4'd0);
    for (int n = 4; n >= 1; n--)
      lead_zero[n] = lead_zero[n+1] && (cur_bcd[n*4 +: 4] == 4'd0);
    blank_digit = lead_zero[digit_idx];
  end
`else
  always_comb blank_digit = 1'b0;
`endif

  always_comb begin
    seg_code    = blank_digit ? 8'hFF : decode_seg(cur_digit);
    seg_code[7] = seg_code[7] & ~cur_dp[digit_idx];
  end

  // Frame snapshot and outgoing word shift register (data path, no reset)
  always_ff @(posedge sys_clk) begin
    if (state == LOAD) begin
      if (digit_idx == 3'd0) begin
        frame_bcd <= bcd_data;
        frame_dp  <= dp_en;
      end
      word <= {sel, seg_code};
    end else if (state == SHIFT && phase == 2'd3) begin
      word <= {word[12:0], 1'b0};
    end
  end

  // Scan sequencer and registered 595 pins
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      digit_idx  <= 3'd0;
      bit_cnt    <= 4'd0;
      phase      <= 2'd0;
      hold_cnt   <= '0;
      stcp       <= 1'b0;
      shcp       <= 1'b0;
      ds         <= 1'b0;
      oe         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      oe <= ~seg_en;
      case (state)
        IDLE: begin
          digit_idx  <= 3'd0;
          stcp       <= 1'b0;
          shcp       <= 1'b0;
          frame_done <= 1'b0;
          if (seg_en) state <= LOAD;
        end
        LOAD: begin
          bit_cnt <= 4'd0;
          phase   <= 2'd0;
          state   <= SHIFT;
        end
        SHIFT: begin
          case (phase)
            2'd0: begin
              ds   <= word[13];
              shcp <= 1'b0;
            end
            2'd2:    shcp <= 1'b1;
            default: ;
          endcase
          phase <= phase + 2'd1;
          if (phase == 2'd3) begin
            if (bit_cnt == 4'd13) state <= LATCH;
            else bit_cnt <= bit_cnt + 4'd1;
          end
        end
        LATCH: begin
          shcp       <= 1'b0;
          stcp       <= 1'b1;
          frame_done <= (digit_idx == 3'd5);
          hold_cnt   <= '0;
          if (!seg_en) begin
            state     <= IDLE;
            digit_idx <= 3'd0;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          stcp       <= 1'b0;
          frame_done <= 1'b0;
          if (!seg_en) begin
            state     <= IDLE;
            digit_idx <= 3'd0;
          end else if (hold_cnt == HOLD_W'(cnt_scan_max - 1)) begin
            state     <= LOAD;
            digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_595_scan_ctrl.sv
// Directed bench for seg_595_scan_ctrl with a short dwell (68-cycle digit period).
module tb_seg_595_scan_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [23:0] bcd_data = 24'h0;
  logic [5:0]  dp_en = 6'h0;
  logic        seg_en = 1'b0;
  logic        stcp, shcp, ds, oe, frame_done;

  int errors = 0;
  int checks = 0;

  logic [13:0] words[$];
  int          bits_q[$];
  int          cyc_q[$];
  logic [13:0] sr = '0;
  int          bits = 0;
  int          shcp_rises = 0;
  int          fd_cnt = 0;
  int          cyc = 0;
  logic        shcp_d = 1'b0;
  logic        stcp_d = 1'b0;

  always #10 sys_clk = ~sys_clk;

  seg_595_scan_ctrl #(.cnt_scan_max(10)) u_dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .bcd_data   (bcd_data),
    .dp_en      (dp_en),
    .seg_en     (seg_en),
    .stcp       (stcp),
    .shcp       (shcp),
    .ds         (ds),
    .oe         (oe),
    .frame_done (frame_done)
  );

  // 595 model: captures ds on shcp rises, records the word on each stcp rise
  always @(negedge sys_clk) begin
    if (shcp && !shcp_d) begin
      sr = {sr[12:0], ds};
      bits++;
      shcp_rises++;
    end
    if (stcp && !stcp_d) begin
      words.push_back(sr);
      bits_q.push_back(bits);
      cyc_q.push_back(cyc);
      bits = 0;
    end
    if (frame_done) fd_cnt++;
    shcp_d = shcp;
    stcp_d = stcp;
    cyc++;
  end

  task automatic wait_words(input int n, input string tag);
    for (int i = 0; i < 1500; i++) begin
      if (words.size() >= n) break;
      @(negedge sys_clk);
    end
    checks++;
    if (words.size() < n) begin
      errors++;
      $display("FAIL %s timeout: words=%0d required=%0d", tag, words.size(), n);
    end
  endtask

  task automatic stop_scan();
    seg_en = 1'b0;
    repeat (100) @(negedge sys_clk);
  endtask

  task automatic start_scan(input logic [23:0] b, input logic [5:0] d);
    words.delete();
    bits_q.delete();
    cyc_q.delete();
    fd_cnt = 0;
    bits = 0;
    bcd_data = b;
    dp_en = d;
    seg_en = 1'b1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    seg_en = 1'b1;
    bcd_data = 24'h123456;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      checks++;
      if ({stcp, shcp, ds, oe, frame_done} !== 5'b00010) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %b required 00010", i, {stcp, shcp, ds, oe, frame_done});
      end
    end
    seg_en = 1'b0;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_basic();
    logic [13:0] exp [6];
    exp = '{14'b000001_10000010, 14'b000010_10010010, 14'b000100_10011001,
            14'b001000_10110000, 14'b010000_10100100, 14'b100000_11111001};
    start_scan(24'h123456, 6'b000000);
    repeat (2) @(negedge sys_clk);
    checks++;
    if (oe !== 1'b0) begin
      errors++;
      $display("FAIL basic_oe: got %b required 0", oe);
    end
    wait_words(6, "basic_words");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (words[i] !== exp[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got %b required %b", i, words[i], exp[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (bits_q[i] != 14) begin
        errors++;
        $display("FAIL basic_bitcount%0d: got %0d required 14", i, bits_q[i]);
      end
    end
    checks++;
    if (cyc_q[1] - cyc_q[0] != 68) begin
      errors++;
      $display("FAIL basic_period: got %0d required 68", cyc_q[1] - cyc_q[0]);
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL basic_frame_done: got %0d required 1", fd_cnt);
    end
    stop_scan();
  endtask

  task automatic test_dp();
    start_scan(24'h123456, 6'b000100);
    wait_words(6, "dp_words");
    checks++;
    if (words[2] !== 14'b000100_00011001) begin
      errors++;
      $display("FAIL dp_digit2: got %b required %b", words[2], 14'b000100_00011001);
    end
    checks++;
    if (words[1] !== 14'b000010_10010010) begin
      errors++;
      $display("FAIL dp_digit1: got %b required %b", words[1], 14'b000010_10010010);
    end
    checks++;
    if (words[3] !== 14'b001000_10110000) begin
      errors++;
      $display("FAIL dp_digit3: got %b required %b", words[3], 14'b001000_10110000);
    end
    stop_scan();
  endtask

  task automatic test_stop_mid_shift();
    int rises;
    bit found = 0;
    start_scan(24'h123456, 6'b000000);
    for (int i = 0; i < 600; i++) begin
      @(negedge sys_clk);
      if (words.size() == 1 && bits == 4) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stop_reach_bit5: words=%0d bits=%0d required 1/4", words.size(), bits);
    end
    checks++;
    if (oe !== 1'b0) begin
      errors++;
      $display("FAIL stop_oe_before: got %b required 0", oe);
    end
    seg_en = 1'b0;
    @(negedge sys_clk);
    checks++;
    if (oe !== 1'b1) begin
      errors++;
      $display("FAIL stop_oe_after: got %b required 1", oe);
    end
    repeat (100) @(negedge sys_clk);
    checks++;
    if (words.size() != 2) begin
      errors++;
      $display("FAIL stop_stcp_count: got %0d required 2", words.size());
    end
    checks++;
    if (words[1] !== 14'b000010_10010010 || bits_q[1] != 14) begin
      errors++;
      $display("FAIL stop_word: got %b/%0d bits required %b/14", words[1], bits_q[1], 14'b000010_10010010);
    end
    rises = shcp_rises;
    repeat (200) @(negedge sys_clk);
    checks++;
    if (shcp_rises != rises || shcp !== 1'b0) begin
      errors++;
      $display("FAIL stop_shcp_quiet: rises %0d->%0d shcp=%b required no change, 0", rises, shcp_rises, shcp);
    end
    checks++;
    if (fd_cnt != 0 || words.size() != 2) begin
      errors++;
      $display("FAIL stop_no_frame: fd=%0d words=%0d required 0/2", fd_cnt, words.size());
    end
  endtask

  task automatic test_midframe_change();
    logic [13:0] exp [7];
    exp = '{14'b000001_10000010, 14'b000010_10010010, 14'b000100_10011001,
            14'b001000_10110000, 14'b010000_10100100, 14'b100000_11111001,
            14'b000001_10010000};
    start_scan(24'h123456, 6'b000000);
    wait_words(2, "mid_words2");
    repeat (30) @(negedge sys_clk);
    bcd_data = 24'h999999;
    wait_words(7, "mid_words7");
    for (int i = 2; i < 7; i++) begin
      checks++;
      if (words[i] !== exp[i]) begin
        errors++;
        $display("FAIL mid_word%0d: got %b required %b", i, words[i], exp[i]);
      end
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL mid_frame_done: got %0d required 1", fd_cnt);
    end
    stop_scan();
  endtask

  task automatic test_blank();
    logic [7:0] exp [6];
`ifdef LEADING_ZERO_BLANK_EN
    exp = '{8'hC0, 8'hA4, 8'hF9, 8'hFF, 8'hFF, 8'h7F};
`else
    exp = '{8'hC0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'h40};
`endif
    start_scan(24'h000120, 6'b100000);
    wait_words(6, "blank_words");
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (words[i] !== {6'b000001 << i, exp[i]}) begin
        errors++;
        $display("FAIL blank_digit%0d: got %b required %b", i, words[i], {6'b000001 << i, exp[i]});
      end
    end
    stop_scan();
    start_scan(24'h00000F, 6'b000000);
    wait_words(6, "hexf_words");
    checks++;
    if (words[0] !== 14'b000001_11111111) begin
      errors++;
      $display("FAIL hexf_digit0: got %b required %b", words[0], 14'b000001_11111111);
    end
    checks++;
`ifdef LEADING_ZERO_BLANK_EN
    if (words[5] !== 14'b100000_11111111) begin
      errors++;
      $display("FAIL hexf_digit5: got %b required %b", words[5], 14'b100000_11111111);
    end
`else
    if (words[5] !== 14'b100000_11000000) begin
      errors++;
      $display("FAIL hexf_digit5: got %b required %b", words[5], 14'b100000_11000000);
    end
`endif
    stop_scan();
  endtask

  task automatic test_async_reset();
    start_scan(24'h123456, 6'b000000);
    repeat (20) @(negedge sys_clk);
    checks++;
    if (oe !== 1'b0) begin
      errors++;
      $display("FAIL arst_running: oe=%b required 0", oe);
    end
    #3 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({stcp, shcp, ds, oe, frame_done} !== 5'b00010) begin
      errors++;
      $display("FAIL arst_immediate: got %b required 00010", {stcp, shcp, ds, oe, frame_done});
    end
    seg_en = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (5) @(negedge sys_clk);
    checks++;
    if ({stcp, shcp, ds, oe, frame_done} !== 5'b00010) begin
      errors++;
      $display("FAIL arst_after: got %b required 00010", {stcp, shcp, ds, oe, frame_done});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_dp();
    test_stop_mid_shift();
    test_midframe_change();
    test_blank();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
